nba_merge_reg: RTL and testbench

//   Multi-port bit-masked register that merges overlapping same-cycle writes with

---
 rtl/nba_merge_reg.sv | 97 +++++++++
 tb/tb_nba_merge_reg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nba_merge_reg.sv
`default_nettype none
// ============================================================================
// Module      : nba_merge_reg
// Description : Multi-port bit-masked shared register; the highest-index port
//               wins per bit, with conflict flag, change strobe and write count.
// Revision    : 1.0 - initial release
// ============================================================================
module nba_merge_reg #(
    parameter int               WIDTH     = 128,
    parameter int               NPORTS    = 2,
    parameter int               LATENCY   = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        wr_en_i,
    input  logic [NPORTS*WIDTH-1:0]  wr_mask_i,
    input  logic [NPORTS*WIDTH-1:0]  wr_data_i,
    output logic [WIDTH-1:0]         q_o,
    output logic                     changed_o,
    output logic                     conflict_o,
    output logic [15:0]              upd_cnt_o
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // Entry 0 is the architectural register; later entries delay it toward q.
    logic [WIDTH-1:0] r_pipe_q [LATENCY];
    logic [LATENCY-1:0] r_cf_q;
    logic             r_changed_q;
    logic [15:0]      r_cnt_q;

    logic [WIDTH-1:0] w_val_d;
    logic [WIDTH-1:0] w_q_d;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_wr_ones;
    logic [WIDTH-1:0] w_wr_zeros;
    logic             w_effective;
    logic             w_conflict_raw;

    // Ascending port order lets later ports overwrite earlier ones per bit.
    always_comb begin
        w_val_d     = r_pipe_q[0];
        w_mask      = '0;
        w_data      = '0;
        w_wr_ones   = '0;
        w_wr_zeros  = '0;
        w_effective = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            w_mask = wr_en_i[p] ? wr_mask_i[p*WIDTH +: WIDTH] : '0;
            w_data = wr_data_i[p*WIDTH +: WIDTH];
            w_val_d     = (w_val_d & ~w_mask) | (w_data & w_mask);
            w_wr_ones   = w_wr_ones  | (w_data & w_mask);
            w_wr_zeros  = w_wr_zeros | (~w_data & w_mask);
            w_effective = w_effective | (|w_mask);
        end
        w_conflict_raw = |(w_wr_ones & w_wr_zeros);
    end

    generate
        if (LATENCY == 1) begin : g_lat_one
            assign w_q_d = w_val_d;
        end else begin : g_lat_multi
            assign w_q_d = r_pipe_q[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_pipe_q[k] <= RESET_VAL;
                r_cf_q[k]   <= 1'b0;
            end
            r_changed_q <= 1'b0;
            r_cnt_q     <= '0;
        end else begin
            r_pipe_q[0] <= w_val_d;
            r_cf_q[0]   <= w_conflict_raw;
            for (int k = 1; k < LATENCY; k++) begin
                r_pipe_q[k] <= r_pipe_q[k-1];
                r_cf_q[k]   <= r_cf_q[k-1];
            end
            r_changed_q <= (w_q_d != r_pipe_q[LATENCY-1]);
            if (w_effective && (r_cnt_q != c_CNT_MAX)) begin
                r_cnt_q <= r_cnt_q + 16'd1;
            end
        end
    end

    assign q_o        = r_pipe_q[LATENCY-1];
    assign conflict_o = r_cf_q[LATENCY-1];
    assign changed_o  = r_changed_q;
    assign upd_cnt_o  = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_nba_merge_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_nba_merge_reg
// Description : Directed bench for three nba_merge_reg configurations against
//               a per-bit reference model plus literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nba_merge_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // d0: 8-bit, 2 ports, latency 1
    logic [1:0]   en8;   logic [15:0]  mk8,   dt8;
    logic [7:0]   q8;    logic ch8, cf8; logic [15:0] cnt8;
    // d1: 128-bit, 2 ports, latency 1
    logic [1:0]   en128; logic [255:0] mk128, dt128;
    logic [127:0] q128;  logic ch128, cf128; logic [15:0] cnt128;
    // d2: 8-bit, 3 ports, latency 3
    logic [2:0]   en3;   logic [23:0]  mk3,   dt3;
    logic [7:0]   q3;    logic ch3, cf3; logic [15:0] cnt3;

    nba_merge_reg #(.WIDTH(8), .NPORTS(2), .LATENCY(1), .RESET_VAL(8'h00)) u_d8 (
        .clk(clk), .rst(rst), .wr_en_i(en8), .wr_mask_i(mk8), .wr_data_i(dt8),
        .q_o(q8), .changed_o(ch8), .conflict_o(cf8), .upd_cnt_o(cnt8));

    nba_merge_reg #(.WIDTH(128), .NPORTS(2), .LATENCY(1), .RESET_VAL(128'h0)) u_d128 (
        .clk(clk), .rst(rst), .wr_en_i(en128), .wr_mask_i(mk128), .wr_data_i(dt128),
        .q_o(q128), .changed_o(ch128), .conflict_o(cf128), .upd_cnt_o(cnt128));

    nba_merge_reg #(.WIDTH(8), .NPORTS(3), .LATENCY(3), .RESET_VAL(8'h00)) u_d3 (
        .clk(clk), .rst(rst), .wr_en_i(en3), .wr_mask_i(mk3), .wr_data_i(dt3),
        .q_o(q3), .changed_o(ch3), .conflict_o(cf3), .upd_cnt_o(cnt3));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: per-bit priority merge, delay line of committed values.
    int W  [3] = '{8, 128, 8};
    int NP [3] = '{2, 2, 3};
    int LT [3] = '{1, 1, 3};
    logic [127:0] m_qh  [3][4];
    bit           m_cfh [3][4];
    bit           m_ch  [3];
    int           m_cnt [3];
    bit           started = 1'b0;

    task automatic model_step(input int d, input logic rs, input logic [7:0] en,
                              input logic [1023:0] mk, input logic [1023:0] dt);
        logic [127:0] nx;
        logic [127:0] old_q;
        bit cf;
        bit eff;
        if (rs) begin
            for (int k = 0; k < 4; k++) begin
                m_qh[d][k]  = '0;
                m_cfh[d][k] = 1'b0;
            end
            m_ch[d]  = 1'b0;
            m_cnt[d] = 0;
        end else begin
            nx  = m_qh[d][0];
            cf  = 1'b0;
            eff = 1'b0;
            for (int p = 0; p < NP[d]; p++) begin
                if (en[p]) begin
                    for (int b = 0; b < W[d]; b++) begin
                        if (mk[p*W[d]+b]) begin
                            eff   = 1'b1;
                            nx[b] = dt[p*W[d]+b];
                            for (int o = 0; o < p; o++) begin
                                if (en[o] && mk[o*W[d]+b] && (dt[o*W[d]+b] != dt[p*W[d]+b]))
                                    cf = 1'b1;
                            end
                        end
                    end
                end
            end
            old_q = m_qh[d][LT[d]-1];
            for (int k = 3; k > 0; k--) begin
                m_qh[d][k]  = m_qh[d][k-1];
                m_cfh[d][k] = m_cfh[d][k-1];
            end
            m_qh[d][0]  = nx;
            m_cfh[d][0] = cf;
            m_ch[d]     = (m_qh[d][LT[d]-1] != old_q);
            if (eff && m_cnt[d] < 65535) m_cnt[d]++;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst, 8'(en8),   1024'(mk8),   1024'(dt8));
        model_step(1, rst, 8'(en128), 1024'(mk128), 1024'(dt128));
        model_step(2, rst, 8'(en3),   1024'(mk3),   1024'(dt3));
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cmp_q8",    128'(q8),     m_qh[0][0]);
            chk("cmp_ch8",   128'(ch8),    128'(m_ch[0]));
            chk("cmp_cf8",   128'(cf8),    128'(m_cfh[0][0]));
            chk("cmp_cnt8",  128'(cnt8),   128'(m_cnt[0]));
            chk("cmp_q128",  q128,         m_qh[1][0]);
            chk("cmp_ch128", 128'(ch128),  128'(m_ch[1]));
            chk("cmp_cf128", 128'(cf128),  128'(m_cfh[1][0]));
            chk("cmp_cnt128",128'(cnt128), 128'(m_cnt[1]));
            chk("cmp_q3",    128'(q3),     m_qh[2][2]);
            chk("cmp_ch3",   128'(ch3),    128'(m_ch[2]));
            chk("cmp_cf3",   128'(cf3),    128'(m_cfh[2][2]));
            chk("cmp_cnt3",  128'(cnt3),   128'(m_cnt[2]));
        end
    end

    task automatic idle();
        en8 = '0;   mk8 = '0;   dt8 = '0;
        en128 = '0; mk128 = '0; dt128 = '0;
        en3 = '0;   mk3 = '0;   dt3 = '0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_q8",   128'(q8),   128'h0);
        chk("rst_ch8",  128'(ch8),  128'h0);
        chk("rst_cnt8", 128'(cnt8), 128'h0);
        chk("rst_q3",   128'(q3),   128'h0);
        rst = 1'b0;

        // Overlapping write: port 1 clears bit 7 that port 0 sets.
        en8   = 2'b11; mk8 = {8'h80, 8'hFF}; dt8 = {8'h00, 8'hFF};
        en128 = 2'b11;
        mk128 = {1'b1, 127'b0, {128{1'b1}}};
        dt128 = {128'b0, {128{1'b1}}};
        tick(); idle();
        chk("t1_q",    128'(q8),   128'h7F);
        chk("t1_cf",   128'(cf8),  128'h1);
        chk("t1_ch",   128'(ch8),  128'h1);
        chk("t1_cnt",  128'(cnt8), 128'h1);
        chk("t2_q",    q128,       {1'b0, {127{1'b1}}});
        chk("t2_cf",   128'(cf128), 128'h1);
        tick();
        chk("t1_ch_drop", 128'(ch8), 128'h0);
        chk("t1_cf_drop", 128'(cf8), 128'h0);

        // Disjoint masks, then agreeing overlap.
        en8 = 2'b11; mk8 = {8'hF0, 8'h0F}; dt8 = {8'hA0, 8'h05};
        tick(); idle();
        chk("t3_q",  128'(q8),  128'hA5);
        chk("t3_cf", 128'(cf8), 128'h0);
        en8 = 2'b11; mk8 = {8'h01, 8'h01}; dt8 = {8'h01, 8'h01};
        tick(); idle();
        chk("t3b_cf",  128'(cf8),  128'h0);
        chk("t3b_q",   128'(q8),   128'hA5);
        chk("t3b_ch",  128'(ch8),  128'h0);
        chk("t3b_cnt", 128'(cnt8), 128'h3);

        // Latency 3: back-to-back writes compose on the internal register.
        en3 = 3'b001; mk3 = {16'h0, 8'hFF}; dt3 = {16'h0, 8'h11};
        tick();
        en3 = 3'b110; mk3 = {8'h0F, 8'h0F, 8'h00}; dt3 = {8'h02, 8'h07, 8'h00};
        chk("t4_qN", 128'(q3), 128'h00);
        tick(); idle();
        chk("t4_qN1", 128'(q3), 128'h00);
        tick();
        chk("t4_qN2",  128'(q3),  128'h11);
        chk("t4_chN2", 128'(ch3), 128'h1);
        chk("t4_cfN2", 128'(cf3), 128'h0);
        tick();
        chk("t4_qN3",  128'(q3),  128'h12);
        chk("t4_chN3", 128'(ch3), 128'h1);
        chk("t4_cfN3", 128'(cf3), 128'h1);
        tick();
        chk("t4_chN4", 128'(ch3), 128'h0);

        // Reset while a write is still in flight.
        en3 = 3'b001; mk3 = {16'h0, 8'hFF}; dt3 = {16'h0, 8'hF0};
        tick(); idle();
        rst = 1'b1;
        chk("t6_qN", 128'(q3), 128'h12);
        tick();
        rst = 1'b0;
        chk("t6_q",   128'(q3),   128'h00);
        chk("t6_ch",  128'(ch3),  128'h0);
        chk("t6_cf",  128'(cf3),  128'h0);
        chk("t6_cnt", 128'(cnt3), 128'h0);
        tick(); tick(); tick();
        chk("t6_q_late",  128'(q3),  128'h00);
        chk("t6_ch_late", 128'(ch3), 128'h0);

        // Zero mask is not counted; then drive the counter into saturation.
        en8 = 2'b11; mk8 = 16'h0000; dt8 = 16'hFFFF;
        tick(); idle();
        chk("t5_nomask", 128'(cnt8), 128'h0);
        for (int i = 0; i < 70000; i++) begin
            en8 = 2'b01; mk8 = 16'h00FF; dt8 = {8'h00, 8'(i)};
            tick();
        end
        idle();
        chk("t5_sat", 128'(cnt8), 128'hFFFF);
        en8 = 2'b10; mk8 = 16'hFF00; dt8 = 16'h5500;
        tick(); idle();
        tick();
        chk("t5_hold", 128'(cnt8), 128'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
